// File: rtl/alu_packet_ctrl_if.sv
// Byte-stream bundle between the packet controller and the UART pair.
//   s_axis_*  : request bytes arriving from uart_rx into the controller
//   m_axis_*  : response bytes leaving the controller towards uart_tx
// Modports:
//   master : the UART side (feeds s_axis, drains m_axis)
//   slave  : the controller side (drives s_axis_tready and m_axis data/valid)
interface alu_packet_ctrl_if;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;

    modport master (
        output s_axis_tdata, s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tvalid,
        output m_axis_tready
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tvalid,
        input  m_axis_tready
    );
endinterface

// File: rtl/alu_packet_ctrl.sv
// Packet front end for an external ALU. Parses a byte stream of
// {opcode, reserved, len_lo, len_hi, operand words (LE)}, folds the operands
// through the ALU one at a time and streams the accumulator back LSB first.
// Ports:
//   clk_i, reset_i        : rising-edge clock, asynchronous active-high reset
//   axis (slave)          : s_axis request stream in, m_axis response stream out
//   alu_op_o/a_o/b_o      : operation and operands, held from start to done
//   alu_start_o           : one-cycle start pulse
//   alu_done_i/result_i   : completion pulse and 64-bit result
//   err_o                 : one-cycle pulse on a rejected or timed-out packet
module alu_packet_ctrl #(
    parameter logic [31:0] TimeoutCycles = 32'd1000000
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    alu_packet_ctrl_if.slave        axis,
    output logic [1:0]              alu_op_o,
    output logic [31:0]             alu_a_o,
    output logic [31:0]             alu_b_o,
    output logic                    alu_start_o,
    input  logic                    alu_done_i,
    input  logic [63:0]             alu_result_i,
    output logic                    err_o
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_RSVD, ST_LEN_LO, ST_LEN_HI, ST_OPERAND, ST_EXEC, ST_RESP, ST_DRAIN
    } state_e;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_BAD = 2'b11;

    function automatic logic [1:0] op_decode(input logic [7:0] code);
        case (code)
            8'had:   op_decode = OP_ADD;
            8'h63:   op_decode = OP_MUL;
            8'h5b:   op_decode = OP_DIV;
            default: op_decode = OP_BAD;
        endcase
    endfunction

    // Division takes exactly two operands, so its length is pinned to 12.
    function automatic logic header_ok(input logic [7:0] code, input logic [7:0] rsvd,
                                       input logic [15:0] len);
        logic [1:0] op_v;
        op_v = op_decode(code);
        header_ok = (op_v != OP_BAD) && (rsvd == 8'h00) && (len[1:0] == 2'b00) &&
                    (len >= 16'd12) && ((op_v != OP_DIV) || (len == 16'd12));
    endfunction

    // States in which the sender is expected to keep bytes coming.
    function automatic logic is_timed(input state_e s);
        is_timed = (s == ST_RSVD) || (s == ST_LEN_LO) || (s == ST_LEN_HI) ||
                   (s == ST_OPERAND) || (s == ST_DRAIN);
    endfunction

    state_e      state_r, state_next_s;
    logic [7:0]  opcode_r, rsvd_r, len_lo_r;
    logic [15:0] cnt_r;
    logic [1:0]  byte_idx_r;
    logic        first_r;
    logic [31:0] operand_r;
    logic [63:0] acc_r;
    logic [2:0]  resp_idx_r;
    logic [31:0] to_cnt_r;
    logic        tready_r, m_tvalid_r, start_r, err_r;
    logic [7:0]  m_tdata_r;
    logic [1:0]  op_r;
    logic [31:0] a_r, b_r;

    logic        accept_s, hdr_ok_s, timeout_hit_s, resp_fire_s, resp_last_s;
    logic [15:0] len_s;
    logic [31:0] word_s;

    assign accept_s      = axis.s_axis_tvalid && tready_r;
    assign len_s         = {axis.s_axis_tdata, len_lo_r};
    assign hdr_ok_s      = header_ok(opcode_r, rsvd_r, len_s);
    assign word_s        = {axis.s_axis_tdata, operand_r[31:8]};
    assign timeout_hit_s = (TimeoutCycles != 32'd0) && !accept_s &&
                           (to_cnt_r == TimeoutCycles - 32'd1);
    assign resp_fire_s   = m_tvalid_r && axis.m_axis_tready;
    assign resp_last_s   = (resp_idx_r == ((op_r == OP_ADD) ? 3'd3 : 3'd7));

    assign axis.s_axis_tready = tready_r;
    assign axis.m_axis_tvalid = m_tvalid_r;
    assign axis.m_axis_tdata  = m_tdata_r;
    assign alu_op_o           = op_r;
    assign alu_a_o            = a_r;
    assign alu_b_o            = b_r;
    assign alu_start_o        = start_r;
    assign err_o              = err_r;

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_next_s = ST_RSVD;
                else          state_next_s = ST_IDLE;
            end
            ST_RSVD: begin
                if (timeout_hit_s) state_next_s = ST_IDLE;
                else if (accept_s) state_next_s = ST_LEN_LO;
                else               state_next_s = ST_RSVD;
            end
            ST_LEN_LO: begin
                if (timeout_hit_s) state_next_s = ST_IDLE;
                else if (accept_s) state_next_s = ST_LEN_HI;
                else               state_next_s = ST_LEN_LO;
            end
            ST_LEN_HI: begin
                if (timeout_hit_s)        state_next_s = ST_IDLE;
                else if (!accept_s)       state_next_s = ST_LEN_HI;
                else if (hdr_ok_s)        state_next_s = ST_OPERAND;
                else if (len_s > 16'd4)   state_next_s = ST_DRAIN;
                else                      state_next_s = ST_IDLE;
            end
            ST_OPERAND: begin
                if (timeout_hit_s) state_next_s = ST_IDLE;
                else if (accept_s && (byte_idx_r == 2'd3) && !first_r) state_next_s = ST_EXEC;
                else               state_next_s = ST_OPERAND;
            end
            ST_EXEC: begin
                if (alu_done_i) state_next_s = (cnt_r == 16'd0) ? ST_RESP : ST_OPERAND;
                else            state_next_s = ST_EXEC;
            end
            ST_RESP: begin
                if (resp_fire_s && resp_last_s) state_next_s = ST_IDLE;
                else                            state_next_s = ST_RESP;
            end
            ST_DRAIN: begin
                if (timeout_hit_s)                      state_next_s = ST_IDLE;
                else if (accept_s && (cnt_r <= 16'd1))  state_next_s = ST_IDLE;
                else                                    state_next_s = ST_DRAIN;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Datapath: header capture, operand assembly, ALU handshake, response and timeout.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            opcode_r   <= 8'h00;
            rsvd_r     <= 8'h00;
            len_lo_r   <= 8'h00;
            cnt_r      <= 16'd0;
            byte_idx_r <= 2'd0;
            first_r    <= 1'b0;
            operand_r  <= 32'd0;
            acc_r      <= 64'd0;
            resp_idx_r <= 3'd0;
            to_cnt_r   <= 32'd0;
            tready_r   <= 1'b0;
            m_tvalid_r <= 1'b0;
            m_tdata_r  <= 8'h00;
            start_r    <= 1'b0;
            err_r      <= 1'b0;
            op_r       <= 2'b00;
            a_r        <= 32'd0;
            b_r        <= 32'd0;
        end else begin
            start_r  <= 1'b0;
            err_r    <= 1'b0;
            tready_r <= (state_next_s != ST_EXEC) && (state_next_s != ST_RESP);

            if (is_timed(state_r) && (TimeoutCycles != 32'd0) && !accept_s && !timeout_hit_s) begin
                to_cnt_r <= to_cnt_r + 32'd1;
            end else begin
                to_cnt_r <= 32'd0;
            end

            if (is_timed(state_r) && timeout_hit_s) begin
                err_r <= 1'b1;
            end

            case (state_r)
                ST_IDLE:   if (accept_s) opcode_r <= axis.s_axis_tdata;
                ST_RSVD:   if (accept_s) rsvd_r   <= axis.s_axis_tdata;
                ST_LEN_LO: if (accept_s) len_lo_r <= axis.s_axis_tdata;
                ST_LEN_HI: begin
                    if (accept_s) begin
                        byte_idx_r <= 2'd0;
                        first_r    <= 1'b1;
                        if (hdr_ok_s) begin
                            op_r  <= op_decode(opcode_r);
                            cnt_r <= len_s - 16'd4;
                        end else begin
                            err_r <= 1'b1;
                            cnt_r <= (len_s > 16'd4) ? (len_s - 16'd4) : 16'd0;
                        end
                    end
                end
                ST_OPERAND: begin
                    if (accept_s) begin
                        operand_r  <= word_s;
                        byte_idx_r <= byte_idx_r + 2'd1;
                        cnt_r      <= (cnt_r != 16'd0) ? (cnt_r - 16'd1) : 16'd0;
                        if (byte_idx_r == 2'd3) begin
                            if (first_r) begin
                                acc_r   <= {32'd0, word_s};
                                first_r <= 1'b0;
                            end else begin
                                a_r     <= acc_r[31:0];
                                b_r     <= word_s;
                                start_r <= 1'b1;
                            end
                        end
                    end
                end
                ST_EXEC: begin
                    if (alu_done_i) begin
                        acc_r <= alu_result_i;
                        if (cnt_r == 16'd0) begin
                            resp_idx_r <= 3'd0;
                            m_tdata_r  <= alu_result_i[7:0];
                            m_tvalid_r <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (resp_fire_s) begin
                        if (resp_last_s) begin
                            m_tvalid_r <= 1'b0;
                        end else begin
                            resp_idx_r <= resp_idx_r + 3'd1;
                            m_tdata_r  <= acc_r[{resp_idx_r + 3'd1, 3'b000} +: 8];
                        end
                    end
                end
                ST_DRAIN: begin
                    if (accept_s) cnt_r <= (cnt_r != 16'd0) ? (cnt_r - 16'd1) : 16'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_packet_ctrl.sv
module tb_alu_packet_ctrl;
    localparam logic [31:0] TO = 32'd20;

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [31:0] word_q_t[$];

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [1:0]  alu_op_o;
    logic [31:0] alu_a_o, alu_b_o;
    logic        alu_start_o, err_o;
    logic        alu_done_drv, glitch_done, alu_done_i;
    logic [63:0] alu_result_i;

    alu_packet_ctrl_if axis();
    assign alu_done_i = alu_done_drv | glitch_done;

    alu_packet_ctrl #(.TimeoutCycles(TO)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .axis(axis.slave),
        .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
        .alu_start_o(alu_start_o), .alu_done_i(alu_done_i),
        .alu_result_i(alu_result_i), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int err_pulses = 0;
    int tvalid_cycles = 0;
    word_q_t exp_a_q, exp_b_q, ops_g;
    byte_q_t raw_g;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // The external ALU as the controller expects it to behave.
    function automatic logic [63:0] alu_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00:   return {32'd0, a} + {32'd0, b};
            2'b01:   return {32'd0, a} * {32'd0, b};
            default: begin
                if (b == 32'd0) return {a, 32'hffffffff};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Reference: fold operands left to right, queue the ALU calls it implies.
    task automatic model_packet(input logic [7:0] opc, output logic [63:0] resp, output int nbytes);
        logic [63:0] acc;
        logic [1:0]  op;
        op  = (opc == 8'had) ? 2'b00 : (opc == 8'h63) ? 2'b01 : 2'b10;
        acc = {32'd0, ops_g[0]};
        for (int i = 1; i < ops_g.size(); i++) begin
            exp_a_q.push_back(acc[31:0]);
            exp_b_q.push_back(ops_g[i]);
            acc = alu_fn(op, acc[31:0], ops_g[i]);
        end
        resp   = acc;
        nbytes = (op == 2'b00) ? 4 : 8;
    endtask

    task automatic add_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) raw_g.push_back(w[8*i +: 8]);
    endtask

    task automatic send(input int gap_max);
        int n;
        foreach (raw_g[i]) begin
            repeat ($urandom_range(0, gap_max)) @(negedge clk_i);
            axis.s_axis_tdata  = raw_g[i];
            axis.s_axis_tvalid = 1'b1;
            n = 0;
            while (axis.s_axis_tready !== 1'b1 && n < 500) begin
                @(negedge clk_i);
                n++;
            end
            if (n >= 500) check("send_timeout", n, 0);
            @(negedge clk_i);
            axis.s_axis_tvalid = 1'b0;
        end
        raw_g.delete();
    endtask

    // stall: 0 always ready, 1 random, 2 hold ready low 20 cycles per byte
    task automatic recv(input logic [63:0] exp_val, input int n, input int stall, input string tag);
        int got, cyc, wait_n;
        logic pend, rdy;
        logic [7:0] held, exp_b;
        got = 0; cyc = 0; wait_n = 0; pend = 1'b0; held = 8'h00; rdy = 1'b0;
        while (got < n && cyc < 3000) begin
            @(negedge clk_i);
            cyc++;
            if (pend) begin
                check({tag, "_hold_valid"}, axis.m_axis_tvalid, 1);
                check({tag, "_hold_data"}, axis.m_axis_tdata, held);
            end
            if (axis.m_axis_tvalid === 1'b1) begin
                case (stall)
                    0:       rdy = 1'b1;
                    1:       rdy = ($urandom_range(0, 1) == 1);
                    default: rdy = (wait_n >= 20);
                endcase
                if (rdy) begin
                    exp_b = exp_val[8*got +: 8];
                    check($sformatf("%s_byte%0d", tag, got), axis.m_axis_tdata, exp_b);
                    got++;
                    pend = 1'b0;
                    wait_n = 0;
                end else begin
                    pend = 1'b1;
                    held = axis.m_axis_tdata;
                    wait_n++;
                end
            end else begin
                rdy  = ($urandom_range(0, 1) == 1);
                pend = 1'b0;
            end
            axis.m_axis_tready = rdy;
        end
        if (got < n) check({tag, "_timeout"}, got, n);
        axis.m_axis_tready = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            check({tag, "_no_extra"}, axis.m_axis_tvalid, 0);
        end
    endtask

    task automatic packet(input logic [7:0] opc, input int gap_max, input int stall,
                          input logic [63:0] exp_val, input int n, input string tag);
        logic [15:0] len;
        len = 16'(4 + 4 * ops_g.size());
        raw_g.push_back(opc);
        raw_g.push_back(8'h00);
        raw_g.push_back(len[7:0]);
        raw_g.push_back(len[15:8]);
        foreach (ops_g[i]) add_word(ops_g[i]);
        send(gap_max);
        recv(exp_val, n, stall, tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_tready"}, axis.s_axis_tready, 0);
        check({tag, "_m_tvalid"}, axis.m_axis_tvalid, 0);
        check({tag, "_m_tdata"}, axis.m_axis_tdata, 0);
        check({tag, "_start"}, alu_start_o, 0);
        check({tag, "_op"}, alu_op_o, 0);
        check({tag, "_a"}, alu_a_o, 0);
        check({tag, "_b"}, alu_b_o, 0);
        check({tag, "_err"}, err_o, 0);
    endtask

    // ALU responder: checks each start against the model, answers after a random delay.
    initial begin
        logic [1:0]  op_h;
        logic [31:0] a_h, b_h, ea, eb;
        int lat;
        alu_done_drv = 1'b0;
        alu_result_i = 64'd0;
        forever begin
            @(negedge clk_i);
            if (alu_start_o === 1'b1) begin
                start_cnt++;
                op_h = alu_op_o; a_h = alu_a_o; b_h = alu_b_o;
                check("alu_start_expected", (exp_a_q.size() != 0), 1);
                ea = a_h; eb = b_h;
                if (exp_a_q.size() != 0) begin
                    ea = exp_a_q.pop_front();
                    eb = exp_b_q.pop_front();
                    check("alu_a", a_h, ea);
                    check("alu_b", b_h, eb);
                end
                lat = $urandom_range(0, 3);
                for (int i = 0; i < lat; i++) begin
                    @(negedge clk_i);
                    check("alu_start_pulse", alu_start_o, 0);
                    check("alu_a_hold", alu_a_o, ea);
                    check("alu_b_hold", alu_b_o, eb);
                end
                alu_result_i = alu_fn(op_h, a_h, b_h);
                alu_done_drv = 1'b1;
                @(negedge clk_i);
                alu_done_drv = 1'b0;
            end
        end
    end

    // Event counters for err_o pulses and response-valid cycles.
    initial begin
        forever begin
            @(negedge clk_i);
            if (err_o === 1'b1) err_pulses++;
            if (axis.m_axis_tvalid === 1'b1) tvalid_cycles++;
        end
    end

    initial begin
        logic [63:0] mv;
        int mn, s0, e0, t0, k, nops;
        logic [7:0]  opc;
        logic [31:0] w;

        reset_i = 1'b1;
        glitch_done = 1'b0;
        axis.s_axis_tdata = 8'h00;
        axis.s_axis_tvalid = 1'b0;
        axis.m_axis_tready = 1'b1;
        repeat (3) @(negedge clk_i);
        check_reset_outputs("reset");
        reset_i = 1'b0;
        @(negedge clk_i);
        check("tready_after_reset", axis.s_axis_tready, 1);

        // add of three operands
        s0 = start_cnt;
        ops_g.delete(); ops_g.push_back(32'd1); ops_g.push_back(32'd2); ops_g.push_back(32'd3);
        model_packet(8'had, mv, mn);
        packet(8'had, 0, 0, 64'h0000000000000006, 4, "add3");
        check("add3_starts", start_cnt - s0, 2);

        // mul overflowing into the upper word
        ops_g.delete(); ops_g.push_back(32'hffffffff); ops_g.push_back(32'd2);
        model_packet(8'h63, mv, mn);
        packet(8'h63, 1, 0, 64'h00000001fffffffe, 8, "mul");

        // div: quotient low, remainder high
        ops_g.delete(); ops_g.push_back(32'd7); ops_g.push_back(32'd2);
        model_packet(8'h5b, mv, mn);
        packet(8'h5b, 1, 1, 64'h0000000100000003, 8, "div");

        // unknown opcode drained, then a valid add
        e0 = err_pulses; t0 = tvalid_cycles;
        raw_g.push_back(8'h11); raw_g.push_back(8'h00); raw_g.push_back(8'h0c); raw_g.push_back(8'h00);
        add_word(32'h5b5b5b5b); add_word(32'h63ad63ad);
        send(1);
        repeat (5) @(negedge clk_i);
        check("badop_err", err_pulses - e0, 1);
        check("badop_no_resp", tvalid_cycles - t0, 0);
        ops_g.delete(); ops_g.push_back(32'd5); ops_g.push_back(32'd7);
        model_packet(8'had, mv, mn);
        packet(8'had, 0, 0, 64'h000000000000000c, 4, "after_badop");

        // nonzero reserved byte (drain 12) and over-long div (drain 12)
        e0 = err_pulses;
        raw_g.push_back(8'had); raw_g.push_back(8'h01); raw_g.push_back(8'h10); raw_g.push_back(8'h00);
        add_word(32'hadadadad); add_word(32'h00000000); add_word(32'h10000000);
        send(2);
        raw_g.push_back(8'h5b); raw_g.push_back(8'h00); raw_g.push_back(8'h10); raw_g.push_back(8'h00);
        add_word(32'h5b001000); add_word(32'h00000010); add_word(32'had000c00);
        send(2);
        // len below the header size: nothing to drain
        raw_g.push_back(8'had); raw_g.push_back(8'h00); raw_g.push_back(8'h02); raw_g.push_back(8'h00);
        send(0);
        repeat (3) @(negedge clk_i);
        check("bad_hdr_errs", err_pulses - e0, 3);
        ops_g.delete(); ops_g.push_back(32'd100); ops_g.push_back(32'd23);
        model_packet(8'h63, mv, mn);
        packet(8'h63, 0, 0, mv, mn, "after_drain");

        // long backpressure on every response byte
        ops_g.delete(); ops_g.push_back(32'h12345678); ops_g.push_back(32'h9abcdef0);
        model_packet(8'h63, mv, mn);
        check("stall_model", mv, 64'h0b00ea4e242d2080);
        packet(8'h63, 0, 2, mv, mn, "stall");

        // stray alu_done while idle must be ignored
        glitch_done = 1'b1;
        @(negedge clk_i);
        glitch_done = 1'b0;
        ops_g.delete(); ops_g.push_back(32'd40); ops_g.push_back(32'd2);
        model_packet(8'had, mv, mn);
        packet(8'had, 0, 0, 64'h000000000000002a, 4, "after_glitch");

        // reset in the middle of an add packet
        t0 = tvalid_cycles;
        raw_g.push_back(8'had); raw_g.push_back(8'h00); raw_g.push_back(8'h10); raw_g.push_back(8'h00);
        raw_g.push_back(8'h09); raw_g.push_back(8'h00);
        send(0);
        reset_i = 1'b1;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        check("tready_after_midreset", axis.s_axis_tready, 1);
        check("midreset_no_resp", tvalid_cycles - t0, 0);
        ops_g.delete(); ops_g.push_back(32'd10); ops_g.push_back(32'd20); ops_g.push_back(32'd30);
        model_packet(8'had, mv, mn);
        packet(8'had, 1, 1, 64'h000000000000003c, 4, "after_midreset");

        // inter-byte timeout inside the first operand
        e0 = err_pulses;
        raw_g.push_back(8'had); raw_g.push_back(8'h00); raw_g.push_back(8'h10); raw_g.push_back(8'h00);
        raw_g.push_back(8'h11);
        send(0);
        repeat (15) @(negedge clk_i);
        check("timeout_not_early", err_pulses - e0, 0);
        repeat (10) @(negedge clk_i);
        check("timeout_err", err_pulses - e0, 1);
        ops_g.delete(); ops_g.push_back(32'd3); ops_g.push_back(32'd4);
        model_packet(8'h63, mv, mn);
        packet(8'h63, 0, 0, 64'h000000000000000c, 8, "after_timeout");

        // random traffic against the reference model
        for (int p = 0; p < 25; p++) begin
            k = $urandom_range(0, 2);
            opc = (k == 0) ? 8'had : (k == 1) ? 8'h63 : 8'h5b;
            nops = (k == 2) ? 2 : $urandom_range(2, 5);
            ops_g.delete();
            for (int i = 0; i < nops; i++) begin
                w = $urandom;
                if ($urandom_range(0, 3) == 0) w = $urandom_range(0, 300);
                if (k == 2 && i == 1 && $urandom_range(0, 7) == 0) w = 32'd0;
                ops_g.push_back(w);
            end
            model_packet(opc, mv, mn);
            packet(opc, 3, 1, mv, mn, $sformatf("rand%0d", p));
        end
        check("alu_queue_empty", exp_a_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_packet_ctrl.md
ALU_PACKET_CTRL -- requirements
Module: alu_packet_ctrl

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 32'd1000000, meaning idle cycles allowed between bytes of one packet; 0 disables the timeout.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset_i, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports s_axis_tdata/tvalid/tready, in/in/out, 8/1/1, byte stream from uart_rx.
REQ-005 SHALL have ports m_axis_tdata/tvalid/tready, out/out/in, 8/1/1, byte stream to uart_tx.
REQ-006 SHALL have port alu_op_o, output, 2, ALU operation: 00 add, 01 mul, 10 div.
REQ-007 SHALL have ports alu_a_o and alu_b_o, output, 32 each, ALU operands.
REQ-008 SHALL have port alu_start_o, output, 1, one-cycle ALU start pulse.
REQ-009 SHALL have ports alu_done_i and alu_result_i, input, 1 and 64, ALU completion pulse and result; div returns {remainder, quotient}.
REQ-010 SHALL have port err_o, output, 1, one-cycle pulse on a rejected or timed-out packet.

Function
REQ-011 SHALL parse packets as: opcode byte, reserved byte, len_lo, len_hi, then 32-bit operands in little-endian order; len counts all bytes including the 4-byte header.
REQ-012 SHALL map opcode 8'had to add, 8'h63 to mul and 8'h5b to div.
REQ-013 SHALL implement states IDLE, RSVD, LEN_LO, LEN_HI, OPERAND, EXEC, RESP and DRAIN.
REQ-014 SHALL accept a byte only on a cycle where s_axis_tvalid and s_axis_tready are both high.
REQ-015 SHALL drive s_axis_tready high in IDLE, RSVD, LEN_LO, LEN_HI, OPERAND and DRAIN, and low in EXEC and RESP.
REQ-016 SHALL check the header when LEN_HI accepts its byte; the packet is valid only if the opcode is known, reserved is 8'h00, len%4==0, len>=12, and len==12 for div.
REQ-017 SHALL, on an invalid header, pulse err_o, enter DRAIN, and discard exactly len-4 bytes, or 0 bytes if len<4, then return to IDLE with no response.
REQ-018 SHALL load the first operand directly into a 64-bit accumulator with upper bits zero, and SHALL NOT start the ALU for it.
REQ-019 SHALL, for each later operand, pulse alu_start_o in the cycle after its 4th byte is accepted, with alu_a_o = acc[31:0] and alu_b_o = operand.
REQ-020 SHALL hold alu_op_o, alu_a_o and alu_b_o stable from start until alu_done_i; on alu_done_i it loads acc with alu_result_i.
REQ-021 SHALL, after the last operand's ALU result, enter RESP and send 4 bytes (acc[31:0]) for add or 8 bytes (acc[63:0]) for mul/div, LSB first.
REQ-022 SHALL keep m_axis_tdata stable and m_axis_tvalid high until m_axis_tready is sampled high; the next byte follows in the next cycle.
REQ-023 SHALL return to IDLE after the last response byte is accepted; a new opcode may be accepted that same cycle or later.
REQ-024 SHALL track remaining bytes with a 16-bit down-counter loaded from len-4; it SHALL NOT wrap below zero.
REQ-025 SHALL, if TimeoutCycles!=0, count idle cycles in RSVD, LEN_LO, LEN_HI, OPERAND and DRAIN; the counter clears on each accepted byte.
REQ-026 SHALL, when the timeout count reaches TimeoutCycles, pulse err_o, discard any partial packet, and enter IDLE.
REQ-027 SHALL ignore alu_done_i outside EXEC; the ALU has no timeout.
REQ-028 SHALL pass a div-by-zero result through unchanged, since the ALU owns that behaviour.

Reset
REQ-029 SHALL, on reset_i high, immediately force: state IDLE, s_axis_tready 0, m_axis_tvalid 0, m_axis_tdata 0, alu_start_o 0, alu_op_o 0, alu_a_o 0, alu_b_o 0, err_o 0, and acc, counters and timeout counter cleared.
REQ-030 SHALL, on reset assertion mid-packet or mid-response, abandon the packet with no further bytes sent.
REQ-031 SHALL drive s_axis_tready to 1 in the first cycle after reset_i deasserts.

Verification
REQ-032 SHALL pass: ad 00 10 00, 01000000 02000000 03000000 -> response 06 00 00 00, with alu_start_o pulsed twice.
REQ-033 SHALL pass: 63 00 0c 00, ffffffff 02000000 -> response fe ff ff ff 01 00 00 00.
REQ-034 SHALL pass: 5b 00 0c 00, 07000000 02000000 -> response 03 00 00 00 01 00 00 00.
REQ-035 SHALL pass: 11 00 0c 00 plus 8 bytes -> one err_o pulse, no m_axis_tvalid, and a following valid add packet answered correctly.
REQ-036 SHALL pass: m_axis_tready low for 20 cycles during each response byte -> tdata stable, no byte lost or duplicated.
REQ-037 SHALL pass: reset_i pulsed after 6 bytes of an add packet -> all outputs at reset values, then the next full packet answered correctly.
